// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle MIPS datapath with memory-ready handshake.
// Optional illegal-opcode trap: define MULTICYCLE_ILLEGAL_TRAP_EN.
module multicycle_ctrl #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [5:0]         op,
    input  logic               mem_ready,
    output logic               pcwrite,
    output logic               branch,
    output logic               irwrite,
    output logic               memwrite,
    output logic               iord,
    output logic               memtoreg,
    output logic               regdst,
    output logic               regwrite,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         pcsrc,
    output logic [1:0]         aluop,
    output logic [STATE_W-1:0] state,
    output logic               halt
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = STATE_W'(0),
        S_DECODE  = STATE_W'(1),
        S_MEMADR  = STATE_W'(2),
        S_MEMRD   = STATE_W'(3),
        S_MEMWB   = STATE_W'(4),
        S_MEMWR   = STATE_W'(5),
        S_RTYPEEX = STATE_W'(6),
        S_RTYPEWB = STATE_W'(7),
        S_BEQEX   = STATE_W'(8),
        S_ADDIEX  = STATE_W'(9),
        S_ADDIWB  = STATE_W'(10),
        S_JEX     = STATE_W'(11),
        S_HALT    = STATE_W'(12)
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    localparam state_t ILLEGAL_NXT = S_HALT;
`else
    localparam state_t ILLEGAL_NXT = S_FETCH;
`endif

    state_t cur;
    state_t nxt;

    logic pcw;
    logic br;
    logic irw;
    logic mw;
    logic rw;
    logic hlt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur <= S_FETCH;
        end else begin
            cur <= nxt;
        end
    end

    always_comb begin
        nxt = S_FETCH;
        case (cur)
            S_FETCH: begin
                nxt = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_RTYP:      nxt = S_RTYPEEX;
                    OP_BEQ:       nxt = S_BEQEX;
                    OP_ADDI:      nxt = S_ADDIEX;
                    OP_J:         nxt = S_JEX;
                    default:      nxt = ILLEGAL_NXT;
                endcase
            end
            S_MEMADR: begin
                nxt = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                nxt = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB:   nxt = S_FETCH;
            S_MEMWR: begin
                nxt = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_RTYPEEX: nxt = S_RTYPEWB;
            S_RTYPEWB: nxt = S_FETCH;
            S_BEQEX:   nxt = S_FETCH;
            S_ADDIEX:  nxt = S_ADDIWB;
            S_ADDIWB:  nxt = S_FETCH;
            S_JEX:     nxt = S_FETCH;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            S_HALT:    nxt = S_HALT;
`endif
            default:   nxt = S_FETCH;
        endcase
    end

    always_comb begin
        pcw      = 1'b0;
        br       = 1'b0;
        irw      = 1'b0;
        mw       = 1'b0;
        rw       = 1'b0;
        hlt      = 1'b0;
        iord     = 1'b0;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        aluop    = 2'b00;
        case (cur)
            S_FETCH: begin
                alusrcb = 2'b01;
                irw     = mem_ready;
                pcw     = mem_ready;
            end
            // Branch target is precomputed into ALUOut here.
            S_DECODE: begin
                alusrcb = 2'b11;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                iord = 1'b1;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                rw       = 1'b1;
            end
            S_MEMWR: begin
                iord = 1'b1;
                mw   = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_RTYPEWB: begin
                regdst = 1'b1;
                rw     = 1'b1;
            end
            S_BEQEX: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                br      = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB: begin
                rw = 1'b1;
            end
            S_JEX: begin
                pcsrc = 2'b10;
                pcw   = 1'b1;
            end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            S_HALT: begin
                hlt = 1'b1;
            end
`endif
            default: begin
                hlt = 1'b0;
            end
        endcase
    end

    // Reset suppresses every write immediately, even mid-instruction.
    assign pcwrite  = pcw & reset_n;
    assign branch   = br & reset_n;
    assign irwrite  = irw & reset_n;
    assign memwrite = mw & reset_n;
    assign regwrite = rw & reset_n;
    assign halt     = hlt & reset_n;
    assign state    = cur;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected control words
// derived from instruction-level rules are queued and checked by a monitor.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic [3:0] st;
        logic       pcwrite;
        logic       branch;
        logic       irwrite;
        logic       memwrite;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic       halt;
    } ctl_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic       clk;
    logic       reset_n;
    logic [5:0] op;
    logic       mem_ready;
    logic       pcwrite;
    logic       branch;
    logic       irwrite;
    logic       memwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic [3:0] state;
    logic       halt;

    int n_pass;
    int n_total;
    ctl_t exp_q[$];

    multicycle_ctrl #(.STATE_W(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .op        (op),
        .mem_ready (mem_ready),
        .pcwrite   (pcwrite),
        .branch    (branch),
        .irwrite   (irwrite),
        .memwrite  (memwrite),
        .iord      (iord),
        .memtoreg  (memtoreg),
        .regdst    (regdst),
        .regwrite  (regwrite),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .pcsrc     (pcsrc),
        .aluop     (aluop),
        .state     (state),
        .halt      (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    // Control word each phase of an instruction must present.
    function automatic ctl_t phase(input int s, input bit mr);
        ctl_t e;
        e = '0;
        e.st = 4'(s);
        case (s)
            0:  begin e.alusrcb = 2'b01; e.irwrite = mr; e.pcwrite = mr; end
            1:  e.alusrcb = 2'b11;
            2:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            3:  e.iord = 1'b1;
            4:  begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
            5:  begin e.iord = 1'b1; e.memwrite = 1'b1; end
            6:  begin e.alusrca = 1'b1; e.aluop = 2'b10; end
            7:  begin e.regdst = 1'b1; e.regwrite = 1'b1; end
            8:  begin
                    e.alusrca = 1'b1; e.aluop = 2'b01;
                    e.pcsrc = 2'b01; e.branch = 1'b1;
                end
            9:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            10: e.regwrite = 1'b1;
            11: begin e.pcsrc = 2'b10; e.pcwrite = 1'b1; end
            12: e.halt = 1'b1;
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic step(input logic [5:0] o, input bit mr, input int s);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        op = o;
        mem_ready = mr;
        exp_q.push_back(phase(s, mr));
    endtask

    function automatic bit rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_wen"}, {27'd0, pcwrite, irwrite, memwrite, regwrite, branch}, 32'd0);
        chk({tag, "_halt"}, 32'(halt), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        check_reset_outputs("rst");
    endtask

    task automatic fetch(input logic [5:0] o, input int wf);
        repeat (wf) step(o, 1'b0, 0);
        step(o, 1'b1, 0);
    endtask

    task automatic mem_wait(input logic [5:0] o, input int wm, input int s);
        repeat (wm) step(o, 1'b0, s);
        step(o, 1'b1, s);
    endtask

    // One full instruction from FETCH back to FETCH.
    task automatic run_instr(input logic [5:0] o, input int wf, input int wm);
        fetch(o, wf);
        step(o, rbit(), 1);
        case (o)
            OP_LW: begin
                step(o, rbit(), 2);
                mem_wait(o, wm, 3);
                step(o, rbit(), 4);
            end
            OP_SW: begin
                step(o, rbit(), 2);
                mem_wait(o, wm, 5);
            end
            OP_RTYP: begin
                step(o, rbit(), 6);
                step(o, rbit(), 7);
            end
            OP_BEQ:  step(o, rbit(), 8);
            OP_ADDI: begin
                step(o, rbit(), 9);
                step(o, rbit(), 10);
            end
            OP_J:    step(o, rbit(), 11);
            default: begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                repeat (12) step(o, rbit(), 12);
                do_reset();
`endif
            end
        endcase
    endtask

    always @(negedge clk) begin
        ctl_t a;
        ctl_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {state, pcwrite, branch, irwrite, memwrite, iord, memtoreg,
                 regdst, regwrite, alusrca, alusrcb, pcsrc, aluop, halt};
            chk($sformatf("cycle_s%0d", e.st), 32'(a), 32'(e));
        end
    end

    initial begin
        logic [5:0] ops [10];
        ops = '{OP_LW, OP_SW, OP_RTYP, OP_BEQ, OP_ADDI, OP_J,
                OP_LW, OP_SW, OP_BAD, 6'b010000};
        n_pass = 0;
        n_total = 0;
        reset_n = 1'b0;
        op = 6'd0;
        mem_ready = 1'b1;
        #2;
        check_reset_outputs("por");

        run_instr(OP_LW, 0, 0);
        run_instr(OP_SW, 0, 3);
        run_instr(OP_RTYP, 0, 0);
        run_instr(OP_BEQ, 0, 0);
        run_instr(OP_ADDI, 2, 0);
        run_instr(OP_J, 0, 0);
        run_instr(OP_BAD, 0, 0);
        for (int i = 0; i < 60; i++) begin
            run_instr(ops[$urandom_range(0, 9)],
                      $urandom_range(0, 2), $urandom_range(0, 3));
        end

        fetch(OP_SW, 0);
        step(OP_SW, 1'b1, 1);
        step(OP_SW, 1'b1, 2);
        step(OP_SW, 1'b0, 5);
        @(posedge clk);
        #1;
        chk("pre_rst_memwrite", 32'(memwrite), 32'd1);
        reset_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        check_reset_outputs("mid_memwr");
        run_instr(OP_LW, 0, 1);
        run_instr(OP_BAD, 1, 0);
        run_instr(OP_J, 0, 0);

        @(posedge clk);
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style control FSM for the multicycle MIPS datapath. Sequences one shared ALU and one unified instruction/data memory across several cycles per instruction.
- Supported instructions match the single-cycle decoder set: R-type, lw, sw, beq, addi, j.
- Sits between the instruction register opcode field and the datapath enables/muxes.
- Adds a memory-ready handshake so the datapath tolerates multi-cycle memory.

Parameters:
- STATE_W, 4, width of state register and of the state debug port.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- op  input  6  opcode from instruction register (IR[31:26])
- mem_ready  input  1  memory completed current access this cycle
- pcwrite  output  1  unconditional PC load
- branch  output  1  conditional PC load (datapath ANDs with ALU zero)
- irwrite  output  1  instruction register load
- memwrite  output  1  memory write request
- iord  output  1  memory address select: 0=PC, 1=ALUOut
- memtoreg  output  1  register write data: 0=ALUOut, 1=Data reg
- regdst  output  1  destination: 0=rt, 1=rd
- regwrite  output  1  register file write
- alusrca  output  1  ALU A: 0=PC, 1=rs reg
- alusrcb  output  2  ALU B: 00=rt reg, 01=const 4, 10=signimm, 11=signimm<<2
- pcsrc  output  2  PC source: 00=ALUResult, 01=ALUOut, 10=jump target
- aluop  output  2  to ALU decoder: 00=add, 01=sub, 10=funct
- state  output  STATE_W  current state (debug)
- halt  output  1  illegal-opcode trap indicator (see Optional Feature)

Behaviour:
- The clock is clk. Reset is reset_n: asynchronous, active-low. Reset forces state=FETCH. While reset_n=0, all write enables (pcwrite, irwrite, memwrite, regwrite, branch) are forced 0, and halt=0.
- All outputs decode combinationally from state. pcwrite and irwrite in FETCH are additionally gated by mem_ready. Unlisted outputs are 0 in each state.
- States and outputs:
  - FETCH(0): iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=pcwrite=mem_ready. Leaves to DECODE when mem_ready=1, else holds.
  - DECODE(1): alusrca=0, alusrcb=11, aluop=00 (branch target into ALUOut). Next state by op:
    - 100011 or 101011 -> MEMADR
    - 000000 -> RTYPEEX
    - 000100 -> BEQEX
    - 001000 -> ADDIEX
    - 000010 -> JEX
    - other -> FETCH
  - MEMADR(2): alusrca=1, alusrcb=10, aluop=00. Next is MEMRD if op=100011, else MEMWR.
  - MEMRD(3): iord=1. Holds until mem_ready=1, then MEMWB.
  - MEMWB(4): regdst=0, memtoreg=1, regwrite=1. Next is FETCH.
  - MEMWR(5): iord=1, memwrite=1 held throughout the state. Holds until mem_ready=1, then FETCH.
  - RTYPEEX(6): alusrca=1, alusrcb=00, aluop=10. Next is RTYPEWB.
  - RTYPEWB(7): regdst=1, memtoreg=0, regwrite=1. Next is FETCH.
  - BEQEX(8): alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1. Next is FETCH.
  - ADDIEX(9): alusrca=1, alusrcb=10, aluop=00. Next is ADDIWB.
  - ADDIWB(10): regdst=0, memtoreg=0, regwrite=1. Next is FETCH.
  - JEX(11): pcsrc=10, pcwrite=1. Next is FETCH.
  - HALT(12): see Optional Feature.
  - Codes 13-15: unreachable; the next-state function maps them to FETCH.
- Cycle counts with mem_ready tied 1:
  - lw 5; sw 4; R-type 4; addi 4; beq 3; j 3.
  - Each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds one cycle.
- op is sampled only in DECODE and MEMADR. The IR holds it stable because irwrite is 0 outside FETCH.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- Reset mid-instruction: abandons it immediately and returns to FETCH. No partial writes are issued after reset_n falls.

Optional Feature:
- Macro: MULTICYCLE_ILLEGAL_TRAP_EN.
- Defined:
  - Unknown opcode in DECODE -> HALT. HALT asserts halt=1, all enables 0, and self-loops until reset.
- Undefined:
  - Unknown opcode in DECODE -> FETCH (executes as a no-op).
  - HALT is unreachable and halt is tied 0.

Test Plan:
- Reset: reset_n=0 mid-MEMWR with memwrite=1 -> state=0 and memwrite=0 within the same cycle (async). After release, irwrite=pcwrite=1 on the first cycle with mem_ready=1.
- lw: op=100011, mem_ready=1 -> state sequence 0,1,2,3,4,0. In state 4: regwrite=1, memtoreg=1, regdst=0.
- sw with wait states: op=101011, mem_ready=0 for 3 cycles in MEMWR -> memwrite=1 for 4 consecutive cycles, then state=0.
- R-type then beq back-to-back: state sequence 0,1,6,7,0,1,8,0. In state 8: aluop=01, branch=1, pcsrc=01.
- Fetch stall: mem_ready=0 for 2 cycles in FETCH -> irwrite=pcwrite=0 for those cycles, state stays 0. Both assert in the third cycle.
- Illegal op=111111:
  - with MULTICYCLE_ILLEGAL_TRAP_EN -> state=12, halt=1 persists for 10+ cycles.
  - without it -> returns to FETCH, halt=0.
